// File: rtl/proj_pkg.sv
// Shared constants and types for the MinHash datapath: default widths, the
// bottom-K sorter's table entry, its all-ones signature and its FSM states.
package proj_pkg;

    localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int INDICE_LEN                    = 8;
    localparam int HASHER_SORTER_SIGNATURE       = 32;

    localparam logic [HASHER_SORTER_SIGNATURE-1:0] SORTER_SIG_MAX = '1;

    typedef struct packed {
        logic                               vld;
        logic [HASHER_SORTER_SIGNATURE-1:0] sig;
        logic [INDICE_LEN-1:0]              idx;
    } sorter_entry_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        STALL = 1'b1
    } sorter_state_e;

endpackage

// File: rtl/proj_topk_slot.sv
// One slot of the bottom-K table: compares the incoming signature against the
// slot and selects the slot's next entry (hold, shift from upper neighbour, load).
module proj_topk_slot
    import proj_pkg::*;
#(
    parameter int SIG_W = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int IDX_W = proj_pkg::INDICE_LEN
) (
    input  logic             own_vld_i,
    input  logic [SIG_W-1:0] own_sig_i,
    input  logic [IDX_W-1:0] own_idx_i,
    input  logic             up_vld_i,
    input  logic [SIG_W-1:0] up_sig_i,
    input  logic [IDX_W-1:0] up_idx_i,
    input  logic [SIG_W-1:0] new_sig_i,
    input  logic [IDX_W-1:0] new_idx_i,
    input  logic             shift_i,
    input  logic             load_i,
    output logic             le_o,
    output logic             eq_o,
    output logic             nxt_vld_o,
    output logic [SIG_W-1:0] nxt_sig_o,
    output logic [IDX_W-1:0] nxt_idx_o
);

    // Using <= places a new beat after equal signatures, preserving arrival order.
    assign le_o = own_vld_i && (own_sig_i <= new_sig_i);
    assign eq_o = own_vld_i && (own_sig_i == new_sig_i);

    always_comb begin
        nxt_vld_o = own_vld_i;
        nxt_sig_o = own_sig_i;
        nxt_idx_o = own_idx_i;
        if (load_i) begin
            nxt_vld_o = 1'b1;
            nxt_sig_o = new_sig_i;
            nxt_idx_o = new_idx_i;
        end else if (shift_i) begin
            nxt_vld_o = up_vld_i;
            nxt_sig_o = up_sig_i;
            nxt_idx_o = up_idx_i;
        end
    end

endmodule

// File: rtl/proj_topk_sorter.sv
// Streaming bottom-K selector: keeps the K smallest signatures of a frame in
// ascending order and publishes them on in_last. Build option: PROJ_SORTER_DEDUP_EN.
module proj_topk_sorter #(
    parameter int INDICES_COUNT = proj_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int SIGNATURE_LEN = proj_pkg::HASHER_SORTER_SIGNATURE,
    parameter int CNT_W         = $clog2(INDICES_COUNT + 1)
) (
    input  logic                                         in_clk,
    input  logic                                         in_rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [SIGNATURE_LEN-1:0]                     in_signature,
    input  logic [INDICE_LEN-1:0]                        in_index,
    input  logic                                         in_last,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]     out_smallest_idx,
    output logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0]  out_smallest_sig,
    output logic [CNT_W-1:0]                             out_count
);
    import proj_pkg::*;

    localparam int PW = $clog2(INDICES_COUNT + 1);
    localparam logic [0:0] ST_ACCUM = ACCUM;
    localparam logic [0:0] ST_STALL = STALL;
`ifdef PROJ_SORTER_DEDUP_EN
    localparam bit DEDUP_EN = 1'b1;
`else
    localparam bit DEDUP_EN = 1'b0;
`endif

    logic [0:0] state_q, state_d;
    logic [INDICES_COUNT-1:0]                     tbl_vld_q, tbl_vld_d;
    logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0]  tbl_sig_q, tbl_sig_d;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]     tbl_idx_q, tbl_idx_d;
    logic                                         out_valid_q;
    logic [INDICES_COUNT-1:0][INDICE_LEN-1:0]     out_idx_q, out_idx_d;
    logic [INDICES_COUNT-1:0][SIGNATURE_LEN-1:0]  out_sig_q, out_sig_d;
    logic [CNT_W-1:0]                             out_cnt_q, out_cnt_d;

    logic [INDICES_COUNT-1:0] le_vec, eq_vec, load_vec, shift_vec;
    logic [PW-1:0]            pos;
    logic                     acc, dup, ins, xfer;

    assign in_ready = (state_q == ST_ACCUM);
    assign acc      = in_valid && in_ready;
    assign dup      = DEDUP_EN && (|eq_vec);
    assign ins      = acc && (pos != PW'(INDICES_COUNT)) && !dup;

    // Valid slots are sorted and contiguous, so the le flags form a thermometer.
    always_comb begin
        pos = '0;
        for (int i = 0; i < INDICES_COUNT; i++) pos = pos + PW'(le_vec[i]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < INDICES_COUNT; gi++) begin : g_slot
            logic                     up_vld;
            logic [SIGNATURE_LEN-1:0] up_sig;
            logic [INDICE_LEN-1:0]    up_idx;
            if (gi == 0) begin : g_head
                assign up_vld = 1'b0;
                assign up_sig = '0;
                assign up_idx = '0;
            end else begin : g_body
                assign up_vld = tbl_vld_q[gi-1];
                assign up_sig = tbl_sig_q[gi-1];
                assign up_idx = tbl_idx_q[gi-1];
            end

            assign load_vec[gi]  = ins && (pos == PW'(gi));
            assign shift_vec[gi] = ins && (pos <  PW'(gi));

            proj_topk_slot #(
                .SIG_W (SIGNATURE_LEN),
                .IDX_W (INDICE_LEN)
            ) u_slot (
                .own_vld_i (tbl_vld_q[gi]),
                .own_sig_i (tbl_sig_q[gi]),
                .own_idx_i (tbl_idx_q[gi]),
                .up_vld_i  (up_vld),
                .up_sig_i  (up_sig),
                .up_idx_i  (up_idx),
                .new_sig_i (in_signature),
                .new_idx_i (in_index),
                .shift_i   (shift_vec[gi]),
                .load_i    (load_vec[gi]),
                .le_o      (le_vec[gi]),
                .eq_o      (eq_vec[gi]),
                .nxt_vld_o (tbl_vld_d[gi]),
                .nxt_sig_o (tbl_sig_d[gi]),
                .nxt_idx_o (tbl_idx_d[gi])
            );

            assign out_idx_d[gi] = tbl_vld_d[gi] ? tbl_idx_d[gi] : '0;
            assign out_sig_d[gi] = tbl_vld_d[gi] ? tbl_sig_d[gi] : '1;
        end
    endgenerate

    always_comb begin
        out_cnt_d = '0;
        for (int i = 0; i < INDICES_COUNT; i++) out_cnt_d = out_cnt_d + CNT_W'(tbl_vld_d[i]);
    end

    // In STALL no beat is accepted, so the post-insert view equals the frozen table.
    always_comb begin
        state_d = state_q;
        xfer    = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (acc && in_last) begin
                    if (!out_valid_q || out_ready) xfer = 1'b1;
                    else                           state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                if (out_valid_q && out_ready) begin
                    xfer    = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_ACCUM;
            tbl_vld_q   <= '0;
            tbl_sig_q   <= '0;
            tbl_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_sig_q   <= '1;
            out_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                tbl_vld_q   <= '0;
                out_valid_q <= 1'b1;
                out_idx_q   <= out_idx_d;
                out_sig_q   <= out_sig_d;
                out_cnt_q   <= out_cnt_d;
            end else begin
                tbl_vld_q <= tbl_vld_d;
                tbl_sig_q <= tbl_sig_d;
                tbl_idx_q <= tbl_idx_d;
                if (out_ready) out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid        = out_valid_q;
    assign out_smallest_idx = out_idx_q;
    assign out_smallest_sig = out_sig_q;
    assign out_count        = out_cnt_q;

endmodule

// File: tb/tb_proj_topk_sorter.sv
// Bench for proj_topk_sorter (K=4): directed frames then a random stream
// compared against a stable-sort reference model of each frame.
module tb_proj_topk_sorter;

    localparam int K  = 4;
    localparam int IW = 8;
    localparam int SW = 32;
    localparam int CW = 3;
    localparam logic [SW-1:0] FF = '1;

    logic                     in_clk = 1'b0;
    logic                     in_rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [SW-1:0]            in_signature = '0;
    logic [IW-1:0]            in_index = '0;
    logic                     in_last = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [K-1:0][IW-1:0]     out_smallest_idx;
    logic [K-1:0][SW-1:0]     out_smallest_sig;
    logic [CW-1:0]            out_count;

    always #5 in_clk = ~in_clk;

    proj_topk_sorter #(
        .INDICES_COUNT (K),
        .INDICE_LEN    (IW),
        .SIGNATURE_LEN (SW),
        .CNT_W         (CW)
    ) dut (
        .in_clk           (in_clk),
        .in_rst_n         (in_rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_signature     (in_signature),
        .in_index         (in_index),
        .in_last          (in_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_smallest_idx (out_smallest_idx),
        .out_smallest_sig (out_smallest_sig),
        .out_count        (out_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [K-1:0][IW-1:0] ei,
                             input logic [K-1:0][SW-1:0] es, input int ec);
        chk({tag, "_valid"}, out_valid, ev);
        chk({tag, "_idx"}, out_smallest_idx, ei);
        chk({tag, "_sig"}, out_smallest_sig, es);
        chk({tag, "_count"}, out_count, ec[CW-1:0]);
        $display("txn %s: valid=%0b count=%0d idx=%h sig=%h", tag, out_valid, out_count,
                 out_smallest_idx, out_smallest_sig);
    endtask

    // Called at posedge+1; leaves at posedge+1 after the accepting edge.
    task automatic beat(input logic [SW-1:0] s, input logic [IW-1:0] i, input logic l);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_signature = s; in_index = i; in_last = l;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge in_clk);
            if (in_ready) done = 1'b1;
            @(posedge in_clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!done) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic consume();
        @(posedge in_clk); #1 out_ready = 1'b1;
        @(posedge in_clk); #1 out_ready = 1'b0;
        @(negedge in_clk);
        chk("consumed_valid", out_valid, 1'b0);
    endtask

    task automatic sync();
        @(posedge in_clk); #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [K-1:0][IW-1:0] idx;
        logic [K-1:0][SW-1:0] sig;
        int                   cnt;
    } res_t;

    res_t          exp_q[$];
    logic [SW-1:0] fr_sig[$];
    logic [IW-1:0] fr_idx[$];
    bit            mon_en = 1'b0;
    int            beats_seen = 0;
    int            pending;

    // Stable sort of the whole frame (optionally dropping repeated signatures), first K kept.
    function automatic res_t model();
        logic [SW-1:0] ls[$];
        logic [IW-1:0] li[$];
        res_t          r;
        bit            skip;
        int            pos;
        for (int b = 0; b < fr_sig.size(); b++) begin
            skip = 1'b0;
`ifdef PROJ_SORTER_DEDUP_EN
            for (int e = 0; e < b; e++) if (fr_sig[e] == fr_sig[b]) skip = 1'b1;
`endif
            if (!skip) begin
                pos = 0;
                for (int e = 0; e < ls.size(); e++) if (ls[e] <= fr_sig[b]) pos++;
                ls.insert(pos, fr_sig[b]);
                li.insert(pos, fr_idx[b]);
            end
        end
        r.cnt = (ls.size() < K) ? ls.size() : K;
        for (int k = 0; k < K; k++) begin
            r.idx[k] = (k < ls.size()) ? li[k] : '0;
            r.sig[k] = (k < ls.size()) ? ls[k] : FF;
        end
        return r;
    endfunction

    always @(negedge in_clk) begin
        if (mon_en && in_rst_n) begin
            pending = exp_q.size();
            chk("rnd_in_ready", in_ready, pending < 2);
            chk("rnd_out_valid", out_valid, pending >= 1);
            if (pending >= 1) begin
                chk("rnd_idx", out_smallest_idx, exp_q[0].idx);
                chk("rnd_sig", out_smallest_sig, exp_q[0].sig);
                chk("rnd_count", out_count, exp_q[0].cnt[CW-1:0]);
                if (out_valid && out_ready) begin
                    $display("txn rnd consume: count=%0d idx=%h", out_count, out_smallest_idx);
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                fr_sig.push_back(in_signature);
                fr_idx.push_back(in_index);
                beats_seen++;
                if (in_last) begin
                    exp_q.push_back(model());
                    fr_sig.delete();
                    fr_idx.delete();
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    bit rdy_run;
    int rem, len;

    initial begin
        // reset state
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        check_out("reset", 1'b0, '0, {K{FF}}, 0);
        sync(); in_rst_n = 1'b1;
        @(negedge in_clk);
        chk("reset_in_ready", in_ready, 1'b1);

        // 1: more beats than K, descending
        sync();
        beat(50, 1, 0); beat(40, 2, 0); beat(30, 3, 0); beat(20, 4, 0); beat(10, 5, 1);
        @(negedge in_clk);
        check_out("t1", 1'b1, {8'd2, 8'd3, 8'd4, 8'd5}, {32'd40, 32'd30, 32'd20, 32'd10}, 4);
        consume();

        // 2: short frame
        sync();
        beat(7, 9, 0); beat(3, 8, 1);
        @(negedge in_clk);
        check_out("t2", 1'b1, {8'd0, 8'd0, 8'd9, 8'd8}, {FF, FF, 32'd7, 32'd3}, 2);
        consume();

        // 3: equal signatures
        sync();
        beat(5, 1, 0); beat(5, 2, 0); beat(5, 3, 1);
        @(negedge in_clk);
`ifdef PROJ_SORTER_DEDUP_EN
        check_out("t3", 1'b1, {8'd0, 8'd0, 8'd0, 8'd1}, {FF, FF, FF, 32'd5}, 1);
`else
        check_out("t3", 1'b1, {8'd0, 8'd3, 8'd2, 8'd1}, {FF, 32'd5, 32'd5, 32'd5}, 3);
`endif
        consume();

        // 4: second frame completes while the first is held
        sync();
        beat(5, 7, 1);
        @(negedge in_clk);
        check_out("t4_first", 1'b1, {8'd0, 8'd0, 8'd0, 8'd7}, {FF, FF, FF, 32'd5}, 1);
        sync();
        beat(1, 6, 1);
        @(negedge in_clk);
        chk("t4_stall_in_ready", in_ready, 1'b0);
        check_out("t4_held", 1'b1, {8'd0, 8'd0, 8'd0, 8'd7}, {FF, FF, FF, 32'd5}, 1);
        sync();
        @(negedge in_clk);
        check_out("t4_held2", 1'b1, {8'd0, 8'd0, 8'd0, 8'd7}, {FF, FF, FF, 32'd5}, 1);
        sync(); out_ready = 1'b1;
        sync(); out_ready = 1'b0;
        @(negedge in_clk);
        check_out("t4_swap", 1'b1, {8'd0, 8'd0, 8'd0, 8'd6}, {FF, FF, FF, 32'd1}, 1);
        chk("t4_resume_in_ready", in_ready, 1'b1);
        consume();

        // 5: reset mid-frame
        sync();
        beat(3, 1, 0); beat(2, 2, 0); beat(1, 3, 0);
        in_rst_n = 1'b0;
        @(negedge in_clk);
        check_out("t5_in_reset", 1'b0, '0, {K{FF}}, 0);
        sync(); in_rst_n = 1'b1;
        @(negedge in_clk);
        check_out("t5_after_reset", 1'b0, '0, {K{FF}}, 0);
        sync();
        beat(9, 4, 1);
        @(negedge in_clk);
        check_out("t5", 1'b1, {8'd0, 8'd0, 8'd0, 8'd4}, {FF, FF, FF, 32'd9}, 1);
        consume();

        // 6: random frames against the model
        sync();
        mon_en  = 1'b1;
        rdy_run = 1'b1;
        fork
            begin
                while (rdy_run) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge in_clk); #1;
                end
            end
            begin
                rem = 200;
                for (int f = 0; f < 8; f++) begin
                    if (f == 7) len = rem;
                    else begin
                        len = $urandom_range(10, 40);
                        if (len > rem - (7 - f)) len = rem - (7 - f);
                    end
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) sync();
                        beat(SW'($urandom_range(0, 63)), IW'($urandom_range(0, 255)), b == len - 1);
                    end
                    rem -= len;
                end
                rdy_run = 1'b0;
            end
        join
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) sync();
        sync();
        chk("drain_results", exp_q.size(), 0);
        chk("beats_accepted", beats_seen, 200);
        chk("frame_closed", fr_sig.size(), 0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
